// File: rtl/pipe_pkg.sv
// Shared pipeline types for the hazard/forwarding control: register index width,
// EX forward-select codes and the shadow-scoreboard slot layout.
package pipe_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    localparam logic [1:0] FWD_REG    = 2'b00;
    localparam logic [1:0] FWD_RESULT = 2'b01;
    localparam logic [1:0] FWD_MEM    = 2'b10;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  wr;
        logic                  load;
    } sb_slot_t;

    // True when a tracked slot will write the given (nonzero) register.
    function automatic logic slot_hit(input sb_slot_t slot, input logic [REG_ADDR_W-1:0] addr);
        return slot.valid & slot.wr & (slot.rd == addr) & (addr != {REG_ADDR_W{1'b0}});
    endfunction

endpackage

// File: rtl/hazard_match.sv
// Per-source comparator: checks one ID-stage source against the EX and MEM
// scoreboard slots and reports {ex_hit, ex_load, mem_hit}.
module hazard_match
    import pipe_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] src_addr,
    input  logic                  src_used,
    input  logic                  id_valid,
    input  sb_slot_t              ex_slot,
    input  sb_slot_t              mem_slot,
    output logic                  ex_hit,
    output logic                  ex_load,
    output logic                  mem_hit
);

    logic qualify_s;

    // Match logic for a single source operand.
    always_comb begin
        qualify_s = src_used & id_valid;
        ex_hit    = qualify_s & slot_hit(ex_slot, src_addr);
        ex_load   = ex_hit & ex_slot.load;
        mem_hit   = qualify_s & slot_hit(mem_slot, src_addr);
    end

endmodule

// File: rtl/hazard_detect.sv
// EX forwarding-select and load-use stall control for the 4-stage pipeline.
// Optional HAZARD_STATS_EN adds stall_count / fwd_count statistics outputs.
module hazard_detect
    import pipe_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] id_rd_addr,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  flush,
    input  logic                  mem_wait,
`ifdef HAZARD_STATS_EN
    output logic [31:0]           stall_count,
    output logic [31:0]           fwd_count,
`endif
    output logic [1:0]            rs1_hazard,
    output logic [1:0]            rs2_hazard,
    output logic                  load_use_stall
);

    sb_slot_t   ex_slot_r;
    sb_slot_t   mem_slot_r;
    sb_slot_t   id_entry_s;
    logic       rs1_ex_hit_s, rs1_ex_load_s, rs1_mem_hit_s;
    logic       rs2_ex_hit_s, rs2_ex_load_s, rs2_mem_hit_s;
    logic       id_bubble_s;
    logic [1:0] rs1_code_s;
    logic [1:0] rs2_code_s;

    hazard_match u_match_rs1 (
        .src_addr (id_rs1_addr),
        .src_used (id_rs1_used),
        .id_valid (id_valid),
        .ex_slot  (ex_slot_r),
        .mem_slot (mem_slot_r),
        .ex_hit   (rs1_ex_hit_s),
        .ex_load  (rs1_ex_load_s),
        .mem_hit  (rs1_mem_hit_s)
    );

    hazard_match u_match_rs2 (
        .src_addr (id_rs2_addr),
        .src_used (id_rs2_used),
        .id_valid (id_valid),
        .ex_slot  (ex_slot_r),
        .mem_slot (mem_slot_r),
        .ex_hit   (rs2_ex_hit_s),
        .ex_load  (rs2_ex_load_s),
        .mem_hit  (rs2_mem_hit_s)
    );

    // Stall decision, ID entry construction and next forward-select codes.
    always_comb begin
        load_use_stall = (rs1_ex_load_s | rs2_ex_load_s) & ~mem_wait & ~flush;
        id_bubble_s    = ~id_valid | flush | load_use_stall;

        // x0 is never a real destination, so it is stored as non-writing.
        id_entry_s.valid = ~id_bubble_s;
        id_entry_s.rd    = id_rd_addr;
        id_entry_s.wr    = id_reg_write & (id_rd_addr != {REG_ADDR_W{1'b0}});
        id_entry_s.load  = id_mem_read;

        // Nearer producer wins; a load in EX is covered by the stall instead.
        if (id_bubble_s) begin
            rs1_code_s = FWD_REG;
        end else if (rs1_ex_hit_s && !rs1_ex_load_s) begin
            rs1_code_s = FWD_RESULT;
        end else if (rs1_mem_hit_s) begin
            rs1_code_s = FWD_MEM;
        end else begin
            rs1_code_s = FWD_REG;
        end

        if (id_bubble_s) begin
            rs2_code_s = FWD_REG;
        end else if (rs2_ex_hit_s && !rs2_ex_load_s) begin
            rs2_code_s = FWD_RESULT;
        end else if (rs2_mem_hit_s) begin
            rs2_code_s = FWD_MEM;
        end else begin
            rs2_code_s = FWD_REG;
        end
    end

    // Scoreboard advance and registered select codes; frozen during mem_wait.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_slot_r  <= '0;
            mem_slot_r <= '0;
            rs1_hazard <= FWD_REG;
            rs2_hazard <= FWD_REG;
        end else if (!mem_wait) begin
            mem_slot_r <= ex_slot_r;
            ex_slot_r  <= id_entry_s;
            rs1_hazard <= rs1_code_s;
            rs2_hazard <= rs2_code_s;
        end else begin
            ex_slot_r  <= ex_slot_r;
            mem_slot_r <= mem_slot_r;
            rs1_hazard <= rs1_hazard;
            rs2_hazard <= rs2_hazard;
        end
    end

`ifdef HAZARD_STATS_EN
    // Statistics: stall cycles and advance edges that register a forward.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= 32'd0;
            fwd_count   <= 32'd0;
        end else if (!mem_wait) begin
            stall_count <= stall_count + {31'd0, load_use_stall};
            fwd_count   <= fwd_count + {31'd0, ((rs1_code_s != FWD_REG) || (rs2_code_s != FWD_REG))};
        end else begin
            stall_count <= stall_count;
            fwd_count   <= fwd_count;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_detect.sv
// Directed self-checking bench for hazard_detect; stats counters checked when
// HAZARD_STATS_EN is defined.
module tb_hazard_detect;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic       id_rs1_used, id_rs2_used, id_reg_write, id_mem_read;
    logic       flush, mem_wait;
    logic [1:0] rs1_hazard, rs2_hazard;
    logic       load_use_stall;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_count, fwd_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hazard_detect dut (
        .clk            (clk),
        .rst            (rst),
        .id_valid       (id_valid),
        .id_rs1_addr    (id_rs1_addr),
        .id_rs2_addr    (id_rs2_addr),
        .id_rs1_used    (id_rs1_used),
        .id_rs2_used    (id_rs2_used),
        .id_rd_addr     (id_rd_addr),
        .id_reg_write   (id_reg_write),
        .id_mem_read    (id_mem_read),
        .flush          (flush),
        .mem_wait       (mem_wait),
`ifdef HAZARD_STATS_EN
        .stall_count    (stall_count),
        .fwd_count      (fwd_count),
`endif
        .rs1_hazard     (rs1_hazard),
        .rs2_hazard     (rs2_hazard),
        .load_use_stall (load_use_stall)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic set_id(input logic v, input logic [4:0] r1, input logic u1,
                          input logic [4:0] r2, input logic u2,
                          input logic [4:0] rd, input logic wr, input logic ld);
        id_valid     = v;
        id_rs1_addr  = r1;
        id_rs1_used  = u1;
        id_rs2_addr  = r2;
        id_rs2_used  = u2;
        id_rd_addr   = rd;
        id_reg_write = wr;
        id_mem_read  = ld;
        #1;
    endtask

    task automatic nop();
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        mem_wait = 1'b0;
        nop();
        tick();
        tick();
        check("reset_rs1", {30'd0, rs1_hazard}, 32'd0);
        check("reset_rs2", {30'd0, rs2_hazard}, 32'd0);
        check("reset_stall", {31'd0, load_use_stall}, 32'd0);
        rst = 1'b0;
        tick();

        // add x5,x1,x2 ; sub x6,x5,x1 back-to-back
        set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0);
        check("b2b_stall", {31'd0, load_use_stall}, 32'd0);
        tick();
        check("b2b_rs1", {30'd0, rs1_hazard}, 32'd1);
        check("b2b_rs2", {30'd0, rs2_hazard}, 32'd0);
        nop();
        tick();

        // add x5 ; nop ; or x7,x1,x5
        set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);
        tick();
        nop();
        tick();
        set_id(1'b1, 5'd1, 1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 1'b0);
        tick();
        check("gap_rs1", {30'd0, rs1_hazard}, 32'd0);
        check("gap_rs2", {30'd0, rs2_hazard}, 32'd2);
        nop();
        tick();

        // lw x8 ; add x9,x8,x8 -> one stall, bubble, then 10/10
        set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd8, 1'b1, 5'd8, 1'b1, 5'd9, 1'b1, 1'b0);
        check("lu_stall_on", {31'd0, load_use_stall}, 32'd1);
        tick();
        check("lu_bubble_rs1", {30'd0, rs1_hazard}, 32'd0);
        check("lu_bubble_rs2", {30'd0, rs2_hazard}, 32'd0);
        check("lu_stall_off", {31'd0, load_use_stall}, 32'd0);
        tick();
        check("lu_rs1", {30'd0, rs1_hazard}, 32'd2);
        check("lu_rs2", {30'd0, rs2_hazard}, 32'd2);
        nop();
        tick();
`ifdef HAZARD_STATS_EN
        check("stall_count", stall_count, 32'd1);
        check("fwd_count", fwd_count, 32'd3);
`endif

        // addi x0,x0,5 ; add x3,x0,x0
        set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd3, 1'b1, 1'b0);
        check("x0_stall", {31'd0, load_use_stall}, 32'd0);
        tick();
        check("x0_rs1", {30'd0, rs1_hazard}, 32'd0);
        check("x0_rs2", {30'd0, rs2_hazard}, 32'd0);
        nop();
        tick();

        // lw x4 ; add x4,x4,x2 flushed ; add x10,x4,x1 sees the load in MEM
        set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd4, 1'b1, 5'd2, 1'b1, 5'd4, 1'b1, 1'b0);
        flush = 1'b1;
        #1;
        check("flush_stall", {31'd0, load_use_stall}, 32'd0);
        tick();
        flush = 1'b0;
        check("flush_rs1", {30'd0, rs1_hazard}, 32'd0);
        check("flush_rs2", {30'd0, rs2_hazard}, 32'd0);
        set_id(1'b1, 5'd4, 1'b1, 5'd1, 1'b1, 5'd10, 1'b1, 1'b0);
        check("post_flush_stall", {31'd0, load_use_stall}, 32'd0);
        tick();
        check("post_flush_rs1", {30'd0, rs1_hazard}, 32'd2);
        nop();
        tick();

        // add x5,x10,x1 ; sub x6,x5,x1 under a 3-cycle mem_wait
        set_id(1'b1, 5'd10, 1'b1, 5'd1, 1'b1, 5'd5, 1'b1, 1'b0);
        tick();
        check("pre_wait_rs1", {30'd0, rs1_hazard}, 32'd2);
        set_id(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0);
        mem_wait = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("wait_rs1", {30'd0, rs1_hazard}, 32'd2);
            check("wait_rs2", {30'd0, rs2_hazard}, 32'd0);
        end
        mem_wait = 1'b0;
        #1;
        tick();
        check("release_rs1", {30'd0, rs1_hazard}, 32'd1);
        check("release_rs2", {30'd0, rs2_hazard}, 32'd0);
        nop();
        tick();

        // mem_wait masks a load-use stall
        set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd8, 1'b1, 5'd8, 1'b1, 5'd9, 1'b1, 1'b0);
        mem_wait = 1'b1;
        #1;
        check("wait_masks_stall", {31'd0, load_use_stall}, 32'd0);
        mem_wait = 1'b0;
        #1;
        check("stall_after_wait", {31'd0, load_use_stall}, 32'd1);

        // reset asserted mid-stall
        rst = 1'b1;
        tick();
        check("rst_mid_stall", {31'd0, load_use_stall}, 32'd0);
        check("rst_mid_rs1", {30'd0, rs1_hazard}, 32'd0);
        check("rst_mid_rs2", {30'd0, rs2_hazard}, 32'd0);
`ifdef HAZARD_STATS_EN
        check("rst_stall_count", stall_count, 32'd0);
        check("rst_fwd_count", fwd_count, 32'd0);
`endif
        rst = 1'b0;
        nop();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_detect.md
Name: hazard_detect

Overview:
- Upstream control for the EX-stage forwarding mux in the 4-stage (IF, ID, EX, MEM/WB) pipeline.
- Tracks destination registers of in-flight instructions in a small shadow scoreboard.
- Compares each ID-stage source against those destinations and produces the registered 2-bit select codes rs1_hazard/rs2_hazard consumed in EX.
- Detects load-use hazards, raises a one-cycle stall and inserts a bubble; honours branch-mispredict flush and memory-wait freeze.

Parameters:
- REG_ADDR_W, 5, register index width.
- NUM_REGS, 32, architectural registers; index 0 is hard-wired zero.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs1_addr  in  REG_ADDR_W  ID source 1 index.
- id_rs2_addr  in  REG_ADDR_W  ID source 2 index.
- id_rs1_used  in  1  instruction reads rs1.
- id_rs2_used  in  1  instruction reads rs2.
- id_rd_addr  in  REG_ADDR_W  ID destination index.
- id_reg_write  in  1  ID instruction writes rd.
- id_mem_read  in  1  ID instruction is a load.
- flush  in  1  branch mispredict; kill the ID instruction.
- mem_wait  in  1  data memory not ready; freeze the whole pipeline.
- rs1_hazard  out  2  EX select for rs1: 00 regfile, 01 result, 10 memtoreg_data.
- rs2_hazard  out  2  same for rs2.
- load_use_stall  out  1  hold IF/ID this cycle.

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Scoreboard has two slots, EX and MEM. Each slot holds {valid, rd, wr, load}, updated on the clk rising edge.
- Advance when mem_wait=0: MEM<=EX; EX<=ID entry.
  - The ID entry is a bubble (valid=0) if id_valid=0, flush=1 or load_use_stall=1.
- Match condition, combinational in ID, for source s in {rs1, rs2}:
  - s_used & id_valid & slot.valid & slot.wr & slot.rd==s & s!=0.
- Select codes, registered at the advance edge:
  - EX-slot match, non-load: code 01 (producer will be in MEM, ALU result).
  - Else MEM-slot match: code 10 (producer will be in WB, memtoreg_data).
  - Else 00.
  - Nearer producer (EX slot) always wins when both slots match.
- load_use_stall: combinational. High when the EX-slot match has load=1 and mem_wait=0 and flush=0.
  - Exactly one bubble is inserted.
  - Next cycle the load sits in the MEM slot, so the same consumer resolves to code 10. No repeated stall.
- Codes registered into EX are 00 whenever a bubble enters EX.
- mem_wait=1: slots and rs*_hazard hold their values; load_use_stall forced 0 (the freeze already holds ID).
- flush=1 (and mem_wait=0): ID entry becomes a bubble; EX/MEM slots advance normally (the branch itself completes).
- Reset: both slot valids 0, rs1_hazard=rs2_hazard=00, load_use_stall=0 (no valid entries). Reset mid-stall clears the stall on the next edge.
- Writes to x0 are never tracked as hazards; id_rd_addr=0 is stored with wr forced 0.
- Regfile is write-first, so producers already in WB need no forwarding from this block.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- Defined: adds outputs stall_count[31:0], fwd_count[31:0].
  - stall_count increments on each cycle load_use_stall=1.
  - fwd_count increments once per advance edge on which any nonzero code is registered.
  - Both wrap at 2^32, clear on rst, hold during mem_wait.
- Undefined: ports and counters absent; core behaviour identical.

Decomposition:
- Shared package pipe_pkg:
  - REG_ADDR_W.
  - Forward-select constants FWD_REG=2'b00, FWD_RESULT=2'b01, FWD_MEM=2'b10.
  - Scoreboard slot struct {valid, rd, wr, load}.
- One natural sub-module: hazard_match, a combinational per-source comparator returning {ex_hit, ex_load, mem_hit}. Instantiate it twice, for rs1 and rs2.

Test Plan:
- add x5 then sub x6,x5,x1 back-to-back -> rs1_hazard=01 on the sub's EX cycle, no stall.
- add x5; nop; or x7,x1,x5 -> rs2_hazard=10, rs1_hazard=00.
- lw x8 then add x9,x8,x8 -> load_use_stall=1 for exactly 1 cycle, bubble codes 00, then rs1_hazard=rs2_hazard=10.
- addi x0,x0,5 then add x3,x0,x0 -> codes 00, no stall; lw x4 then add x4,x4,x2 with flush=1 on the add -> no stall, bubble, codes 00.
- mem_wait held 3 cycles while add x5 then sub x6,x5 are in flight -> outputs frozen, codes resume correctly (01) after release; rst asserted mid-stall -> all outputs 00/0 next edge.
- HAZARD_STATS_EN: run the load-use plus two forwarding sequences -> stall_count=1, fwd_count=3.
